i2c_burst_sequencer: RTL
========================

Name: i2c_burst_sequencer

Overview:
Command-level front end that sits directly upstream of i2c_master and drives its byte-transfer handshake. It accepts one command per transaction: 7-bit device address, read/write, and length. For writes it first buffers the payload, then issues the complete transaction so the master is never starved. For reads it emits each received byte as a one-cycle strobe, and it reports completion, NACK and bus errors.

Parameters:
MAX_BYTES, 16, payload buffer depth and largest legal cmd_len
LEN_WIDTH, $clog2(MAX_BYTES+1), width of cmd_len and the internal byte counters

Ports:
clk_in  input  1  system clock; all logic rising-edge
reset_n  input  1  synchronous reset, active low
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_read  input  1  1 = read, 0 = write
cmd_addr  input  7  7-bit device address
cmd_len  input  LEN_WIDTH  payload bytes, 0..MAX_BYTES (0 = address-only probe)
wr_valid  input  1  write payload byte offered
wr_ready  output  1  payload byte consumed when wr_valid && wr_ready
wr_data  input  8  write payload byte
rd_valid  output  1  one-cycle strobe, rd_data valid
rd_data  output  8  received byte
busy  output  1  command in progress
done  output  1  one-cycle strobe at end of every accepted command
status_nack  output  1  sticky until next accept; slave NACKed address or write byte
status_err  output  1  sticky until next accept; start/arbitration error or illegal cmd_len
address  output  8  to master: {cmd_addr, cmd_read}
transfer_start  output  1  to master
transfer_continues  output  1  to master
data_tx  output  8  to master
transfer_ready  input  1  from master
interrupt  input  1  from master, byte finished
transaction_complete  input  1  from master
nack  input  1  from master
start_err  input  1  from master
arbitration_err  input  1  from master
data_rx  input  8  from master

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE.
  - All outputs 0: cmd_ready, wr_ready, rd_valid, rd_data, busy, done, status_*, address, transfer_start, transfer_continues, data_tx.
  - Reset mid-transaction drops transfer_start and transfer_continues on that edge. The buffer is invalidated.
- States: IDLE, LOAD, START, XFER, DRAIN, DONE.
- IDLE
  - cmd_ready = transfer_ready.
  - On accept, latch the command, clear status_nack and status_err, set busy = 1.
  - cmd_len > MAX_BYTES: set status_err and go to DONE with no bus activity.
  - Write with cmd_len > 0: go to LOAD. Otherwise go to START.
- LOAD
  - wr_ready = 1.
  - Each handshake stores wr_data into buf[count] and increments count.
  - When cmd_len bytes are stored, go to START on the next cycle. A wr_valid gap only stalls.
- START
  - address <= {cmd_addr, cmd_read}, transfer_start <= 1, transfer_continues <= (cmd_len != 0).
  - Go to XFER. k (interrupt index) = 0.
- XFER, on each interrupt (k = 0 is the address byte):
  - start_err or arbitration_err, or !transaction_complete: set status_err, abort.
  - nack, and either k == 0 or the command is a write: set status_nack, abort.
  - Otherwise, in the same edge:
    - transfer_start <= 0.
    - If k < cmd_len: transfer_continues <= (k+1 < cmd_len); for writes, data_tx <= buf[k].
    - For reads with k >= 1: rd_data <= data_rx and rd_valid pulses for one cycle. The master NACKing the final read byte is expected and not flagged.
    - k increments.
    - If k == cmd_len: go to DRAIN.
- Abort: transfer_start <= 0, transfer_continues <= 0, go to DRAIN.
- Timing: data_tx and transfer_continues for byte k+1 are registered on the edge following interrupt k, before the master needs them. No stall path toward the master exists.
- DRAIN: wait for transfer_ready, then go to DONE.
- DONE: done = 1 for one cycle, busy <= 0, go to IDLE. Status outputs hold until the next accept.
- Simultaneous events: an interrupt on the same cycle as cmd_valid is impossible because cmd_ready is 0 while busy. Error inputs take priority over nack.

Test Plan:
- Write cmd addr 0x2A, len 3, payload 0xDE 0xAD 0xBE → address = 0x54.
  - transfer_continues after interrupts k = 0, 1, 2 is 1, 1, 0.
  - data_tx is 0xDE, 0xAD, 0xBE in order.
  - done pulses once; status_nack = 0.
- Read cmd addr 0x10, len 7; model returns 0xFE..0x54 → address = 0x21.
  - Seven rd_valid strobes carry the matching bytes.
  - The final master NACK leaves status_nack = 0.
- Write len 2, slave NACKs the address → status_nack = 1.
  - transfer_continues = 0 the cycle after interrupt; no data_tx update; done after transfer_ready.
- Write len 4 with wr_valid gaps of 5 cycles → transfer_start stays 0 until all 4 bytes are buffered.
- cmd_len = MAX_BYTES+1 → no transfer_start; status_err = 1; done pulses within 3 cycles.
- reset_n low during XFER of an 8-byte write → next edge: transfer_start = 0, transfer_continues = 0, busy = 0; after transfer_ready, cmd_ready = 1.

Source files
------------

// File: rtl/i2c_burst_sequencer.sv
// Command-level front end for i2c_master: buffers write payloads, issues the
// whole transaction, strobes out read bytes and reports done/NACK/error status.
module i2c_burst_sequencer #(
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned LEN_WIDTH = $clog2(MAX_BYTES + 1)
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_read,
  input  logic [6:0]           cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_data,
  output logic                 rd_valid,
  output logic [7:0]           rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 status_nack,
  output logic                 status_err,
  output logic [7:0]           address,
  output logic                 transfer_start,
  output logic                 transfer_continues,
  output logic [7:0]           data_tx,
  input  logic                 transfer_ready,
  input  logic                 interrupt,
  input  logic                 transaction_complete,
  input  logic                 nack,
  input  logic                 start_err,
  input  logic                 arbitration_err,
  input  logic [7:0]           data_rx
);
  localparam int unsigned IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, LOAD, START, XFER, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic                 read_q;
  logic [6:0]           addr_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] k;
  logic [7:0]           payload_buf [MAX_BYTES];

  logic accept, wr_fire, last_byte, len_bad, bus_err, bus_nack, more_after;
  logic [LEN_WIDTH:0] k_inc;

  assign cmd_ready = reset_n && (state == IDLE) && transfer_ready;
  assign wr_ready  = (state == LOAD);
  assign done      = (state == DONE);

  assign accept    = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign last_byte = wr_fire && ((count + LEN_WIDTH'(1)) == len_q);
  assign len_bad   = cmd_len > MAX_LEN;
  assign bus_err   = start_err || arbitration_err || !transaction_complete;
  // A NACK on a read data byte is the master ending the read, not a failure.
  assign bus_nack  = nack && ((k == '0) || !read_q);
  assign k_inc      = {1'b0, k} + (LEN_WIDTH + 1)'(1);
  assign more_after = k_inc < {1'b0, len_q};

  always_ff @(posedge clk_in) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) begin
        if (len_bad)                          state_nxt = DONE;
        else if (!cmd_read && cmd_len != '0)  state_nxt = LOAD;
        else                                  state_nxt = START;
      end
      LOAD:  if (last_byte) state_nxt = START;
      START: state_nxt = XFER;
      XFER:  if (interrupt && (bus_err || bus_nack || k == len_q)) state_nxt = DRAIN;
      DRAIN: if (transfer_ready) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payload storage needs no reset; a reset invalidates it via count.
  always_ff @(posedge clk_in) begin
    if (wr_fire) payload_buf[count[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      read_q             <= 1'b0;
      addr_q             <= '0;
      len_q              <= '0;
      count              <= '0;
      k                  <= '0;
      busy               <= 1'b0;
      status_nack        <= 1'b0;
      status_err         <= 1'b0;
      rd_valid           <= 1'b0;
      rd_data            <= '0;
      address            <= '0;
      transfer_start     <= 1'b0;
      transfer_continues <= 1'b0;
      data_tx            <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          read_q      <= cmd_read;
          addr_q      <= cmd_addr;
          len_q       <= cmd_len;
          count       <= '0;
          busy        <= 1'b1;
          status_nack <= 1'b0;
          status_err  <= len_bad;
        end
        LOAD: if (wr_fire) count <= count + LEN_WIDTH'(1);
        START: begin
          address            <= {addr_q, read_q};
          transfer_start     <= 1'b1;
          transfer_continues <= (len_q != '0);
          k                  <= '0;
        end
        XFER: if (interrupt) begin
          if (bus_err || bus_nack) begin
            status_err         <= status_err | bus_err;
            status_nack        <= status_nack | (!bus_err);
            transfer_start     <= 1'b0;
            transfer_continues <= 1'b0;
          end else begin
            transfer_start <= 1'b0;
            // Next byte's controls are staged on the edge that finishes byte k.
            if (k < len_q) begin
              transfer_continues <= more_after;
              if (!read_q) data_tx <= payload_buf[k[IDX_W-1:0]];
            end
            if (read_q && k != '0) begin
              rd_data  <= data_rx;
              rd_valid <= 1'b1;
            end
            k <= k + LEN_WIDTH'(1);
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
